module_input_reader: RTL and testbench

Input-side counterpart to the LED counter/driver. It samples a bank of active-low board inputs (push-buttons or DIP switches) and passes each one through a two-flop synchronizer. The bank is debounced as a group against a stable-time counter. Downstream logic receives a clean active-high value, a one-cycle update strobe, per-bit rise/fall masks and a wrapping 6-bit press counter, which matches the width of the LED bank.

---
 rtl/module_input_reader_pkg.sv | 11 +
 rtl/module_input_reader_sync2.sv | 24 ++
 rtl/module_input_reader.sv | 93 +++++++++
 tb/tb_module_input_reader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/module_input_reader_pkg.sv
// Shared types and widths for the board-input reader.
package pkg_input_reader;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } state_t;

  localparam int PRESS_CNT_W = 6;

endpackage

// File: rtl/module_input_reader_sync2.sv
// Two-flop synchronizer bank. Both stages reset to RESET_VAL.
module module_sync2 #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/module_input_reader.sv
// Debounces a bank of active-low board inputs as a group and reports
// committed changes with a one-cycle strobe, rise/fall masks and a press counter.
module module_input_reader
  import pkg_input_reader::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 270000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_n_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       rise_o,
  output logic [WIDTH-1:0]       fall_o,
  output logic                   stable_o,
  output logic [PRESS_CNT_W-1:0] press_count_o
);

  localparam int              CNT_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;

  module_sync2 #(
    .WIDTH     (WIDTH),
    .RESET_VAL ({WIDTH{1'b1}})
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_n_i),
    .q   (sync_q)
  );

  assign s         = ~sync_q;
  assign rise_next = cand & ~data_o;
  assign fall_next = ~cand & data_o;
  assign stable_o  = (state == ST_STABLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_STABLE;
      cnt           <= '0;
      cand          <= '0;
      data_o        <= '0;
      valid_o       <= 1'b0;
      rise_o        <= '0;
      fall_o        <= '0;
      press_count_o <= '0;
    end else begin
      valid_o <= 1'b0;
      rise_o  <= '0;
      fall_o  <= '0;
      case (state)
        ST_STABLE: begin
          if (s != data_o) begin
            cand  <= s;
            cnt   <= '0;
            state <= ST_CHANGING;
          end
        end
        ST_CHANGING: begin
          // Any movement of the sampled bank restarts the stability window.
          if (s != cand) begin
            cand <= s;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_STABLE;
            if (cand != data_o) begin
              data_o  <= cand;
              valid_o <= 1'b1;
              rise_o  <= rise_next;
              fall_o  <= fall_next;
              if (rise_next != '0) begin
                press_count_o <= press_count_o + PRESS_CNT_W'(1);
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_STABLE;
      endcase
    end
  end

endmodule

// File: tb/tb_module_input_reader.sv
// Self-checking bench for module_input_reader with WIDTH = 4, DEBOUNCE = 4.
module tb_module_input_reader;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_n;
  logic [W-1:0] data;
  logic         valid;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         stable;
  logic [5:0]   press_count;

  module_input_reader #(.WIDTH(W), .DEBOUNCE(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_n_i        (in_n),
    .data_o        (data),
    .valid_o       (valid),
    .rise_o        (rise),
    .fall_o        (fall),
    .stable_o      (stable),
    .press_count_o (press_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: a bank value commits on the edge its run of identical
  // synchronized samples first reaches D+1, provided it differs from the output
  int           n_chk = 0;
  int           n_err = 0;
  int           pulses = 0;
  logic [W-1:0] m_data = '0;
  logic [5:0]   m_cnt = '0;
  logic [W-1:0] p1 = '0, p2 = '0, last_s = '0;
  int           run = D + 2;
  logic         e_valid = 1'b0;
  logic [W-1:0] e_rise = '0, e_fall = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    e_valid = 1'b0;
    e_rise  = '0;
    e_fall  = '0;
    if (rst) begin
      m_data = '0;
      m_cnt  = '0;
      p1     = '0;
      p2     = '0;
      last_s = '0;
      run    = D + 2;
    end else begin
      s  = p2;
      p2 = p1;
      p1 = ~in_n;
      if (s == last_s) begin
        if (run < D + 2) run++;
      end else begin
        run = 1;
      end
      last_s = s;
      if (run == D + 1 && s != m_data) begin
        e_valid = 1'b1;
        e_rise  = s & ~m_data;
        e_fall  = ~s & m_data;
        if (e_rise != '0) m_cnt = m_cnt + 6'd1;
        m_data = s;
      end
    end
  endtask

  // driver: one clock, model update, then compare away from the edge
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (valid === 1'b1) pulses++;
    check("data", 32'(data), 32'(m_data));
    check("valid", 32'(valid), 32'(e_valid));
    check("rise", 32'(rise), 32'(e_rise));
    check("fall", 32'(fall), 32'(e_fall));
    check("stable", 32'(stable), 32'(run >= D + 1));
    check("press_count", 32'(press_count), 32'(m_cnt));
  endtask

  task automatic hold(input logic [W-1:0] v, input int n);
    in_n = v;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_stable", 32'(stable), 32'h1);
    check("rst_count", 32'(press_count), 32'h0);
    rst = 1'b0;
  endtask

  logic [5:0] c0;

  initial begin
    rst  = 1'b1;
    in_n = 4'b1111;

    // 1: reset, then idle
    do_reset();
    pulses = 0;
    hold(4'b1111, 20);
    check("idle_pulses", 32'(pulses), 32'd0);

    // 2: clean press
    pulses = 0;
    hold(4'b1110, 10);
    check("press_data", 32'(data), 32'h1);
    check("press_count1", 32'(press_count), 32'd1);
    check("press_pulses", 32'(pulses), 32'd1);

    // 3: bounce, ending low
    hold(4'b1111, 10);
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      hold(4'b1110, 2);
      hold(4'b1111, 2);
    end
    hold(4'b1110, 12);
    check("bounce_pulses", 32'(pulses), 32'd1);
    check("bounce_data", 32'(data), 32'h1);

    // 4: glitch
    hold(4'b1111, 10);
    pulses = 0;
    c0 = press_count;
    hold(4'b1110, 2);
    hold(4'b1111, 12);
    check("glitch_pulses", 32'(pulses), 32'd0);
    check("glitch_data", 32'(data), 32'h0);
    check("glitch_count", 32'(press_count), 32'(m_cnt));

    // 5: simultaneous swap, then release-only
    hold(4'b1110, 10);
    c0 = m_cnt;
    hold(4'b1101, 10);
    check("swap_data", 32'(data), 32'h2);
    check("swap_count", 32'(press_count), 32'(c0 + 6'd1));
    hold(4'b1111, 10);
    check("release_data", 32'(data), 32'h0);
    check("release_count", 32'(press_count), 32'(c0 + 6'd1));

    // 6: wrap after 64 presses
    c0 = m_cnt;
    for (int i = 0; i < 64; i++) begin
      hold(4'b1110, 8);
      hold(4'b1111, 8);
    end
    check("wrap_count", 32'(press_count), 32'(c0));

    // 6: reset while changing aborts the update
    pulses = 0;
    hold(4'b1110, 4);
    check("abort_changing", 32'(stable), 32'h0);
    in_n = 4'b1111;
    do_reset();
    hold(4'b1111, 12);
    check("abort_pulses", 32'(pulses), 32'd0);

    // randomized bank activity
    for (int i = 0; i < 300; i++) begin
      hold(4'($urandom_range(0, 15)), $urandom_range(1, 8));
    end
    hold(4'b1111, 10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
